// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, 32x32 signed, one Booth step per clock.
// Define MULT_RESTART_EN to let a start pulse during RUN abort and restart the operation.
module booth_mult_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

`ifdef MULT_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] mcand;
    logic [64:0] prod;
    logic [64:0] prod_step;
    logic [32:0] upper_sum;
    logic [4:0]  count;
    logic        load;
    logic        step;
    logic        finish;

    // Upper half is kept one bit wider so that -A with A = 0x80000000 stays positive;
    // the extra bit becomes the sign after the shift, which is why no explicit shift appears.
    always_comb begin
        upper_sum = {prod[64], prod[64:33]};
        case (prod[1:0])
            2'b01:   upper_sum = {prod[64], prod[64:33]} + {mcand[31], mcand};
            2'b10:   upper_sum = {prod[64], prod[64:33]} - {mcand[31], mcand};
            default: upper_sum = {prod[64], prod[64:33]};
        endcase
        prod_step = {upper_sum, prod[32:1]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load           = 1'b0;
        step           = 1'b0;
        finish         = 1'b0;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_MULT) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (ctrl_MULT && RESTART_EN) begin
                    load = 1'b1;
                end else begin
                    step = 1'b1;
                    if (count == 5'd31) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                data_resultRDY = 1'b1;
                if (ctrl_MULT) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand <= '0;
            prod  <= '0;
            count <= '0;
        end else if (load) begin
            mcand <= data_operandA;
            prod  <= {32'b0, data_operandB, 1'b0};
            count <= '0;
        end else if (step) begin
            prod  <= prod_step;
            count <= count + 5'd1;
        end
    end

    // Results are captured from the final step so they are already valid in the DONE cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (finish) begin
            data_result    <= prod_step[32:1];
            data_exception <= ~((&prod_step[64:32]) | ~(|prod_step[64:32]));
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed corner cases plus random operands
// checked against a 64-bit integer multiply.
module tb_booth_mult_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    booth_mult_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int at);
        exp_t   r;
        longint p;
        p     = longint'($signed(x)) * longint'($signed(y));
        r.res = p[31:0];
        r.exc = (p != longint'($signed(p[31:0])));
        r.at  = at;
        return r;
    endfunction

    // Called at a falling edge; the start is sampled in cycle n, result due in cycle n+33.
    task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y, output int n);
        ctrl_MULT     = 1'b1;
        data_operandA = x;
        data_operandB = y;
        n = cyc;
        sb.push_back(model(x, y, n + 33));
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0) return;
            @(negedge clock);
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL rdy_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && data_resultRDY) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_rdy: got RDY at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check_output("result", data_result, e.res);
                check_output("exception", data_exception, e.exc);
                check_output("rdy_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int m;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clock);
        check_output("reset_result", data_result, 0);
        check_output("reset_exception", data_exception, 0);
        check_output("reset_rdy", data_resultRDY, 0);
        check_output("reset_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Positive product with busy window check
        apply_stimulus(32'd3, 32'd5, n);
        for (int i = 0; i < 34; i++) begin
            check_output("busy_window", busy, ((cyc - n) >= 1 && (cyc - n) <= 32) ? 1 : 0);
            @(negedge clock);
        end
        wait_drain(40);

        apply_stimulus(-32'sd7, 32'd6, n);          wait_drain(40);
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, n); wait_drain(40);
        apply_stimulus(32'h0001_0000, 32'h0001_0000, n); wait_drain(40);
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, n); wait_drain(40);
        apply_stimulus(32'h8000_0000, 32'd1, n);      wait_drain(40);

        // Reset mid-operation: outputs clear at once, no RDY for the aborted op
        apply_stimulus(32'd9, 32'd9, n);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_output("abort_result", data_result, 0);
        check_output("abort_exception", data_exception, 0);
        check_output("abort_rdy", data_resultRDY, 0);
        check_output("abort_busy", busy, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        apply_stimulus(32'd2, 32'd4, n);
        wait_drain(40);
        repeat (3) @(negedge clock);

        // Start pulse during RUN
        apply_stimulus(32'd2, 32'd3, n);
        repeat (4) @(negedge clock);
`ifdef MULT_RESTART_EN
        sb.delete();
        apply_stimulus(32'd4, 32'd4, m);
`else
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd4;
        data_operandB = 32'd4;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
`endif
        wait_drain(45);
        repeat (2) @(negedge clock);

        // Back-to-back: new start held in the DONE cycle
        apply_stimulus(32'd7, 32'd3, n);
        repeat (32) @(negedge clock);
        apply_stimulus(32'd10, 32'd10, m);
        wait_drain(80);

        // Random operands, including sign-heavy corner values
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : {{16{ra[15]}}, ra[15:0]};
                1: rb = {{16{rb[15]}}, rb[15:0]};
                default: ;
            endcase
            apply_stimulus(ra, rb, n);
            wait_drain(40);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
